// File: rtl/led_matrix_pkg.sv
// Shared constants and helpers for the LED matrix scanner.
// Latency: none (package only).
// Backpressure: none (package only).
//
// Contents: drive polarity constants, default parameter values and the
// flat segment index helper used to map (row, col) onto the segment vector.
package led_matrix_pkg;

    // Anode rows source current when high; cathode columns sink when low.
    localparam logic ROW_ON = 1'b1;
    localparam logic COL_ON = 1'b0;

    localparam int DEF_ROWS     = 3;
    localparam int DEF_COLS     = 3;
    localparam int DEF_TICK_DIV = 1024;
    localparam int DEF_BRIGHT_W = 3;

    // Bit position of the LED at row r, column c in the flat segment vector.
    function automatic int seg_index(input int r, input int c, input int cols);
        return r * cols + c;
    endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Scan prescaler: divides clk into one tick every TICK_DIV cycles.
// Latency: tick is combinational from the counter register.
// Backpressure: none; clear holds the counter at zero.
//
// Ports:
//   clk      - system clock
//   clear    - synchronous clear (reset or scan disabled), holds count at 0
//   tick     - high on the last cycle of each TICK_DIV period
//   pre_zero - high while the count is 0 (start of a tick period)
module scan_prescaler #(
    parameter int TICK_DIV = 1024
) (
    input  logic clk,
    input  logic clear,
    output logic tick,
    output logic pre_zero
);

    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    logic [PRE_W-1:0] pre_q;
    logic [PRE_W-1:0] pre_d;

    // With TICK_DIV == 1 the count is permanently 0, so tick is high every cycle.
    assign tick     = (pre_q == PRE_LAST);
    assign pre_zero = (pre_q == '0);

    always_comb begin
        pre_d = pre_q + 1'b1;
        if (tick) begin
            pre_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

endmodule

// File: rtl/led_matrix_scanner.sv
// Time-multiplexed ROWS x COLS LED matrix driver with PWM and frame buffering.
// Latency: all outputs registered, 1 cycle after the counter/buffer state.
// Backpressure: none; free-running scan, enable low blanks and restarts.
//
// Ports:
//   clk, rst    - system clock, synchronous active-high reset
//   enable      - scan enable; low blanks outputs and holds counters at 0
//   segments    - flat pattern, bit r*COLS+c = LED (r,c), 1 = lit
//   brightness  - on-ticks per row slot, sampled once per frame
//   rows        - anode drive, 1 = sourcing (at most one bit set)
//   cols        - cathode drive, 0 = sinking
//   row_idx     - row currently scanned
//   frame_start - one-cycle pulse following each frame load
module led_matrix_scanner
    import led_matrix_pkg::*;
#(
    parameter int ROWS     = DEF_ROWS,
    parameter int COLS     = DEF_COLS,
    parameter int TICK_DIV = DEF_TICK_DIV,
    parameter int BRIGHT_W = DEF_BRIGHT_W,
    localparam int ROW_W   = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [ROWS*COLS-1:0] segments,
    input  logic [BRIGHT_W-1:0]  brightness,
    output logic [ROWS-1:0]      rows,
    output logic [COLS-1:0]      cols,
    output logic [ROW_W-1:0]     row_idx,
    output logic                 frame_start
);

    localparam logic [BRIGHT_W-1:0] SLOT_LAST = {BRIGHT_W{1'b1}};
    localparam logic [ROW_W-1:0]    ROW_LAST  = ROW_W'(ROWS - 1);

    logic tick;
    logic pre_zero;
    logic load;
    logic row_on;

    logic [BRIGHT_W-1:0]  slot_q, slot_d;
    logic [ROW_W-1:0]     row_q, row_d;
    logic [ROWS*COLS-1:0] frame_buf_q, frame_buf_d;
    logic [BRIGHT_W-1:0]  bright_buf_q, bright_buf_d;
    logic [ROWS-1:0]      rows_q, rows_d;
    logic [COLS-1:0]      cols_q, cols_d;
    logic [ROW_W-1:0]     row_idx_q, row_idx_d;
    logic                 frame_start_q, frame_start_d;

    scan_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_scan_prescaler (
        .clk      (clk),
        .clear    (rst || !enable),
        .tick     (tick),
        .pre_zero (pre_zero)
    );

    // Slot and row counters; slot wrap advances the row.
    always_comb begin
        slot_d = slot_q;
        row_d  = row_q;
        if (!enable) begin
            slot_d = '0;
            row_d  = '0;
        end else if (tick) begin
            slot_d = slot_q + 1'b1;
            if (slot_q == SLOT_LAST) begin
                row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end
        end
    end

    // Inputs are only captured at the very start of a frame so a frame is
    // always drawn from one consistent pattern/brightness snapshot.
    assign load = enable && pre_zero && (slot_q == '0) && (row_q == '0);

    always_comb begin
        frame_buf_d  = frame_buf_q;
        bright_buf_d = bright_buf_q;
        if (load) begin
            frame_buf_d  = segments;
            bright_buf_d = brightness;
        end
    end

    // Slot 0 is always dark: the row index only changes in slot 0, so the
    // column lines settle before the next row is sourced (no ghosting).
    assign row_on = enable && (slot_q != '0) && (slot_q <= bright_buf_q);

    always_comb begin
        rows_d = {ROWS{~ROW_ON}};
        cols_d = {COLS{~COL_ON}};
        for (int r = 0; r < ROWS; r++) begin
            if (row_on && (row_q == ROW_W'(r))) begin
                rows_d[r] = ROW_ON;
                for (int c = 0; c < COLS; c++) begin
                    cols_d[c] = frame_buf_q[seg_index(r, c, COLS)] ? COL_ON : ~COL_ON;
                end
            end
        end
        row_idx_d     = enable ? row_q : '0;
        frame_start_d = load;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q        <= '0;
            row_q         <= '0;
            frame_buf_q   <= '0;
            bright_buf_q  <= '0;
            rows_q        <= {ROWS{~ROW_ON}};
            cols_q        <= {COLS{~COL_ON}};
            row_idx_q     <= '0;
            frame_start_q <= 1'b0;
        end else begin
            slot_q        <= slot_d;
            row_q         <= row_d;
            frame_buf_q   <= frame_buf_d;
            bright_buf_q  <= bright_buf_d;
            rows_q        <= rows_d;
            cols_q        <= cols_d;
            row_idx_q     <= row_idx_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign rows        = rows_q;
    assign cols        = cols_q;
    assign row_idx     = row_idx_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Testbench for led_matrix_scanner (ROWS=3, COLS=3, TICK_DIV=4, BRIGHT_W=2).
// Latency: compares registered outputs on the falling edge.
// Backpressure: none.
module tb_led_matrix_scanner;

    localparam int ROWS     = 3;
    localparam int COLS     = 3;
    localparam int TD       = 4;
    localparam int BW       = 2;
    localparam int SLOTS    = 4;
    localparam int SLOT_CYC = SLOTS * TD;
    localparam int FRAME    = ROWS * SLOT_CYC;

    logic       clk;
    logic       rst;
    logic       enable;
    logic [8:0] segments;
    logic [1:0] brightness;
    logic [2:0] rows;
    logic [2:0] cols;
    logic [1:0] row_idx;
    logic       frame_start;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Reference model state: position within the frame since the last restart.
    int         m_cyc;
    logic [8:0] m_fbuf;
    logic [1:0] m_bbuf;
    logic [2:0] exp_rows;
    logic [2:0] exp_cols;
    logic [1:0] exp_idx;
    logic       exp_fs;

    led_matrix_scanner #(
        .ROWS     (ROWS),
        .COLS     (COLS),
        .TICK_DIV (TD),
        .BRIGHT_W (BW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .segments    (segments),
        .brightness  (brightness),
        .rows        (rows),
        .cols        (cols),
        .row_idx     (row_idx),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs after each edge, derived from the frame position.
    always @(posedge clk) begin
        int  pos;
        int  slot;
        int  row;
        bit  lit;
        if (rst) begin
            exp_rows = 3'b000; exp_cols = 3'b111; exp_idx = 2'd0; exp_fs = 1'b0;
            m_cyc = 0; m_fbuf = '0; m_bbuf = '0;
        end else if (!enable) begin
            exp_rows = 3'b000; exp_cols = 3'b111; exp_idx = 2'd0; exp_fs = 1'b0;
            m_cyc = 0;
        end else begin
            pos  = m_cyc % FRAME;
            slot = (pos / TD) % SLOTS;
            row  = pos / SLOT_CYC;
            lit  = (slot >= 1) && (slot <= int'(m_bbuf));
            exp_rows = lit ? 3'(1 << row) : 3'b000;
            exp_cols = lit ? ~3'(m_fbuf >> (row * COLS)) : 3'b111;
            exp_idx  = 2'(row);
            exp_fs   = (pos == 0);
            if (pos == 0) begin
                m_fbuf = segments;
                m_bbuf = brightness;
            end
            m_cyc++;
        end
    end

    task automatic wait_frame(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_start !== 1'b1 && n < 200);
        total_cnt++;
        if (frame_start !== 1'b1)
            $display("FAIL %s_wait_frame: frame_start=%b after %0d cycles, want 1", name, frame_start, n);
        else
            pass_cnt++;
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b1; segments = 9'b101_010_101; brightness = 2'd3;
        repeat (3) begin
            @(negedge clk);
            total_cnt++;
            if ({rows, cols, row_idx, frame_start} !== 9'b000_111_00_0)
                $display("FAIL reset_hold: rows=%b cols=%b idx=%0d fs=%b, want 000 111 0 0", rows, cols, row_idx, frame_start);
            else
                pass_cnt++;
        end
        rst = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (frame_start !== 1'b1) $display("FAIL reset_release_fs: fs=%b, want 1", frame_start);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (frame_start !== 1'b0) $display("FAIL reset_fs_width: fs=%b, want 0", frame_start);
        else pass_cnt++;
    endtask

    task automatic test_pattern();
        wait_frame("pattern");
        for (int k = 0; k < FRAME; k++) begin
            if (k != 0) @(negedge clk);
            total_cnt++;
            if ({rows, cols, row_idx, frame_start} !== {exp_rows, exp_cols, exp_idx, exp_fs})
                $display("FAIL pattern_model k=%0d: got %b %b %0d %b, want %b %b %0d %b", k, rows, cols, row_idx, frame_start, exp_rows, exp_cols, exp_idx, exp_fs);
            else pass_cnt++;
            total_cnt++;
            if (!$onehot0(rows)) $display("FAIL pattern_onehot k=%0d: rows=%b, want at most one bit", k, rows);
            else pass_cnt++;
            if (k < 4) begin
                total_cnt++;
                if ({rows, cols} !== 6'b000_111) $display("FAIL pattern_blank k=%0d: rows=%b cols=%b, want 000 111", k, rows, cols);
                else pass_cnt++;
            end else if (k < 16) begin
                total_cnt++;
                if ({rows, cols} !== 6'b001_010) $display("FAIL pattern_row0 k=%0d: rows=%b cols=%b, want 001 010", k, rows, cols);
                else pass_cnt++;
            end else if (k >= 20 && k < 32) begin
                total_cnt++;
                if ({rows, cols} !== 6'b010_101) $display("FAIL pattern_row1 k=%0d: rows=%b cols=%b, want 010 101", k, rows, cols);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 4 * FRAME; k++) begin
            @(negedge clk);
            total_cnt++;
            if ({rows, cols, row_idx, frame_start} !== {exp_rows, exp_cols, exp_idx, exp_fs})
                $display("FAIL random_model k=%0d: got %b %b %0d %b, want %b %b %0d %b", k, rows, cols, row_idx, frame_start, exp_rows, exp_cols, exp_idx, exp_fs);
            else pass_cnt++;
            total_cnt++;
            if (!$onehot0(rows)) $display("FAIL random_onehot k=%0d: rows=%b, want at most one bit", k, rows);
            else pass_cnt++;
            if ($urandom_range(0, 7) == 0) begin
                segments   = 9'($urandom);
                brightness = 2'($urandom_range(0, 3));
            end
            enable = ($urandom_range(0, 63) != 0);
        end
        enable = 1'b1;
    endtask

    task automatic test_brightness();
        int lit0, lit1, lit2;
        segments = 9'b111_111_111; brightness = 2'd1;
        wait_frame("bright1");
        lit0 = 0; lit1 = 0; lit2 = 0;
        for (int k = 0; k < FRAME; k++) begin
            if (k != 0) @(negedge clk);
            total_cnt++;
            if ({rows, cols, row_idx, frame_start} !== {exp_rows, exp_cols, exp_idx, exp_fs})
                $display("FAIL bright1_model k=%0d: got %b %b %0d %b, want %b %b %0d %b", k, rows, cols, row_idx, frame_start, exp_rows, exp_cols, exp_idx, exp_fs);
            else pass_cnt++;
            if (rows[0] === 1'b1) lit0++;
            if (rows[1] === 1'b1) lit1++;
            if (rows[2] === 1'b1) lit2++;
        end
        total_cnt++;
        if (lit0 != TD || lit1 != TD || lit2 != TD)
            $display("FAIL bright1_ontime: lit cycles %0d %0d %0d, want %0d each", lit0, lit1, lit2, TD);
        else pass_cnt++;
        brightness = 2'd0;
        wait_frame("bright0");
        lit0 = 0;
        for (int k = 0; k < FRAME; k++) begin
            if (k != 0) @(negedge clk);
            if (rows !== 3'b000) lit0++;
        end
        total_cnt++;
        if (lit0 != 0) $display("FAIL bright0_dark: %0d lit cycles, want 0", lit0);
        else pass_cnt++;
    endtask

    task automatic test_no_tear();
        segments = 9'b101_010_101; brightness = 2'd3;
        wait_frame("tear_a");
        for (int k = 0; k < FRAME; k++) begin
            if (k != 0) @(negedge clk);
            total_cnt++;
            if ({rows, cols, row_idx, frame_start} !== {exp_rows, exp_cols, exp_idx, exp_fs})
                $display("FAIL tear_model k=%0d: got %b %b %0d %b, want %b %b %0d %b", k, rows, cols, row_idx, frame_start, exp_rows, exp_cols, exp_idx, exp_fs);
            else pass_cnt++;
            if (k >= 20 && k < 32) begin
                total_cnt++;
                if ({rows, cols} !== 6'b010_101) $display("FAIL tear_old_row1 k=%0d: rows=%b cols=%b, want 010 101", k, rows, cols);
                else pass_cnt++;
            end else if (k >= 36) begin
                total_cnt++;
                if ({rows, cols} !== 6'b100_010) $display("FAIL tear_old_row2 k=%0d: rows=%b cols=%b, want 100 010", k, rows, cols);
                else pass_cnt++;
            end
            if (k == 20) segments = 9'h1FF;
        end
        wait_frame("tear_b");
        for (int k = 0; k < FRAME; k++) begin
            if (k != 0) @(negedge clk);
            if ((k % SLOT_CYC) >= TD) begin
                total_cnt++;
                if (cols !== 3'b000) $display("FAIL tear_new k=%0d: cols=%b, want 000", k, cols);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_enable();
        segments = 9'b101_010_101; brightness = 2'd3;
        wait_frame("enable");
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            total_cnt++;
            if ({rows, cols, row_idx, frame_start} !== {exp_rows, exp_cols, exp_idx, exp_fs})
                $display("FAIL enable_model k=%0d: got %b %b %0d %b, want %b %b %0d %b", k, rows, cols, row_idx, frame_start, exp_rows, exp_cols, exp_idx, exp_fs);
            else pass_cnt++;
        end
        enable = 1'b0;
        repeat (5) begin
            @(negedge clk);
            total_cnt++;
            if ({rows, cols, row_idx, frame_start} !== 9'b000_111_00_0)
                $display("FAIL enable_low: rows=%b cols=%b idx=%0d fs=%b, want 000 111 0 0", rows, cols, row_idx, frame_start);
            else pass_cnt++;
        end
        enable = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (frame_start !== 1'b1) $display("FAIL enable_rise_fs: fs=%b, want 1", frame_start);
        else pass_cnt++;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 3) begin
                total_cnt++;
                if (rows !== 3'b000) $display("FAIL enable_slot0_dark: rows=%b, want 000", rows);
                else pass_cnt++;
            end else if (k == 4) begin
                total_cnt++;
                if (rows !== 3'b001) $display("FAIL enable_row0_lit: rows=%b, want 001", rows);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_mid_reset();
        wait_frame("midrst");
        for (int k = 1; k <= 44; k++) begin
            @(negedge clk);
            total_cnt++;
            if ({rows, cols, row_idx, frame_start} !== {exp_rows, exp_cols, exp_idx, exp_fs})
                $display("FAIL midrst_model k=%0d: got %b %b %0d %b, want %b %b %0d %b", k, rows, cols, row_idx, frame_start, exp_rows, exp_cols, exp_idx, exp_fs);
            else pass_cnt++;
        end
        rst = 1'b1;
        @(negedge clk);
        total_cnt++;
        if ({rows, cols, row_idx, frame_start} !== 9'b000_111_00_0)
            $display("FAIL midrst_values: rows=%b cols=%b idx=%0d fs=%b, want 000 111 0 0", rows, cols, row_idx, frame_start);
        else pass_cnt++;
        rst = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (frame_start !== 1'b1 || row_idx !== 2'd0)
            $display("FAIL midrst_restart: fs=%b idx=%0d, want 1 0", frame_start, row_idx);
        else pass_cnt++;
        for (int k = 1; k < SLOT_CYC; k++) begin
            @(negedge clk);
            total_cnt++;
            if ({rows, cols, row_idx, frame_start} !== {exp_rows, exp_cols, exp_idx, exp_fs} || row_idx !== 2'd0)
                $display("FAIL midrst_row0 k=%0d: got %b %b %0d %b, want %b %b 0 %b", k, rows, cols, row_idx, frame_start, exp_rows, exp_cols, exp_fs);
            else pass_cnt++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_pattern();
        test_random();
        test_brightness();
        test_no_tear();
        test_enable();
        test_mid_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
